// File: rtl/blinkspeed_pkg.sv
// ============================================================================
// Module      : blinkspeed_pkg
// Description : Shared constants and state encoding for the LED blink speed
//               and sequence controller.
// Contents    : SPEED_W, SPEED_MAX, state encodings ST_MANUAL/ST_AUTO/ST_PAUSE
//               and the state_t enumeration built on them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blinkspeed_pkg;

  localparam int                 SPEED_W   = 2;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 2'd3;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  typedef enum logic [1:0] {
    S_MANUAL = ST_MANUAL,
    S_AUTO   = ST_AUTO,
    S_PAUSE  = ST_PAUSE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/blink_prescaler.sv
// ============================================================================
// Module      : blink_prescaler
// Description : Free-running prescaler counter with a speed-dependent STEP
//               decode. STEP fires when the low (CNT_W-speed) bits of the
//               counter are all ones, so the period is 2^(CNT_W-speed).
// Ports       : CLK      - system clock
//               RST      - asynchronous active-high reset
//               i_speed  - current speed setting (0 = slowest)
//               i_gate   - forces STEP low while set (counter keeps running)
//               o_step   - one-cycle step enable
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_prescaler
  import blinkspeed_pkg::*;
#(
  parameter int CNT_W = 25
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_gate,
  output logic               o_step
);

  localparam logic [CNT_W-1:0] c_ONES = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_mask;

  // Never cleared by a speed change, so switching speed does not restart
  // the current period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Each speed step drops one bit off the top of the compare window,
  // halving the period.
  assign w_mask = c_ONES >> i_speed;
  assign o_step = ((r_cnt & w_mask) == w_mask) && !i_gate;

endmodule

`default_nettype wire

// File: rtl/blink_seq_ctrl.sv
// ============================================================================
// Module      : blink_seq_ctrl
// Description : Speed/sequence controller for the LED blink datapath. Owns the
//               2-bit speed setting driven by UP/DOWN/MODE pulses, generates
//               the prescaled STEP enable, and provides an auto-ramp mode that
//               sweeps speed 0->3->0 with pause/resume.
// Ports       : CLK    - system clock
//               RST    - asynchronous active-high reset
//               UP     - one-cycle pulse, speed up
//               DOWN   - one-cycle pulse, speed down
//               MODE   - one-cycle pulse, manual/auto toggle
//               SPEED  - current speed (0 = slowest)
//               STEP   - one-cycle enable to the LED pattern counter
//               AUTO   - high in AUTO or PAUSE
//               PAUSED - high in PAUSE
// Config      : BLINK_SPEED_SAT_EN - when defined, manual UP/DOWN saturate at
//               3/0; otherwise manual speed arithmetic wraps modulo 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_seq_ctrl
  import blinkspeed_pkg::*;
#(
  parameter int CNT_W = 25,
  parameter int DWELL = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               UP,
  input  logic               DOWN,
  input  logic               MODE,
  output logic [SPEED_W-1:0] SPEED,
  output logic               STEP,
  output logic               AUTO,
  output logic               PAUSED
);

  localparam int               DW_W         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  c_DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic             c_DIR_UP     = 1'b1;
  localparam logic             c_DIR_DOWN   = 1'b0;

  state_t             r_state,  w_nxt_state;
  logic [SPEED_W-1:0] r_speed,  w_nxt_speed;
  logic [DW_W-1:0]    r_dwell,  w_nxt_dwell;
  logic               r_dir,    w_nxt_dir;

  logic               w_step;
  logic               w_paused;
  logic               w_both;

  blink_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .CLK     (CLK),
    .RST     (RST),
    .i_speed (r_speed),
    .i_gate  (w_paused),
    .o_step  (w_step)
  );

  assign w_both   = UP && DOWN;
  assign w_paused = (r_state == S_PAUSE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_MANUAL;
      r_speed <= '0;
      r_dwell <= '0;
      r_dir   <= c_DIR_UP;
    end else begin
      r_state <= w_nxt_state;
      r_speed <= w_nxt_speed;
      r_dwell <= w_nxt_dwell;
      r_dir   <= w_nxt_dir;
    end
  end

  // MODE outranks UP+DOWN, which outranks STEP-driven ramping.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_speed = r_speed;
    w_nxt_dwell = r_dwell;
    w_nxt_dir   = r_dir;

    case (r_state)
      S_MANUAL: begin
        if (MODE) begin
          w_nxt_state = S_AUTO;
          w_nxt_dwell = '0;
          w_nxt_dir   = c_DIR_UP;
        end else if (UP && !DOWN) begin
`ifdef BLINK_SPEED_SAT_EN
          if (r_speed != SPEED_MAX) begin
            w_nxt_speed = r_speed + 2'd1;
          end
`else
          w_nxt_speed = r_speed + 2'd1;
`endif
        end else if (DOWN && !UP) begin
`ifdef BLINK_SPEED_SAT_EN
          if (r_speed != '0) begin
            w_nxt_speed = r_speed - 2'd1;
          end
`else
          w_nxt_speed = r_speed - 2'd1;
`endif
        end
      end

      S_AUTO: begin
        if (MODE) begin
          w_nxt_state = S_MANUAL;
        end else if (w_both) begin
          w_nxt_state = S_PAUSE;
        end else if (w_step) begin
          if (r_dwell == c_DWELL_LAST) begin
            w_nxt_dwell = '0;
            // Endpoints bounce straight to the neighbouring level so each
            // extreme is held for one dwell only.
            if (r_dir == c_DIR_UP) begin
              if (r_speed == SPEED_MAX) begin
                w_nxt_dir   = c_DIR_DOWN;
                w_nxt_speed = SPEED_MAX - 2'd1;
              end else begin
                w_nxt_speed = r_speed + 2'd1;
              end
            end else begin
              if (r_speed == '0) begin
                w_nxt_dir   = c_DIR_UP;
                w_nxt_speed = 2'd1;
              end else begin
                w_nxt_speed = r_speed - 2'd1;
              end
            end
          end else begin
            w_nxt_dwell = r_dwell + {{(DW_W-1){1'b0}}, 1'b1};
          end
        end
      end

      S_PAUSE: begin
        if (MODE) begin
          w_nxt_state = S_MANUAL;
        end else if (w_both) begin
          w_nxt_state = S_AUTO;
        end
      end

      default: begin
        w_nxt_state = S_MANUAL;
      end
    endcase
  end

  assign SPEED  = r_speed;
  assign STEP   = w_step;
  assign AUTO   = (r_state != S_MANUAL);
  assign PAUSED = w_paused;

endmodule

`default_nettype wire

// File: tb/tb_blink_seq_ctrl.sv
// ============================================================================
// Module      : tb_blink_seq_ctrl
// Description : Self-checking bench for blink_seq_ctrl with CNT_W=4, DWELL=2.
//               Table-driven manual-mode vectors plus directed sequences for
//               the auto ramp, pause/resume and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blink_seq_ctrl;

  typedef struct {
    logic       up;
    logic       down;
    logic       mode;
    logic [1:0] speed;
    logic       exp_auto;
    logic       paused;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] speed;
  logic       step;
  logic       auto_out;
  logic       paused;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  blink_seq_ctrl #(
    .CNT_W (4),
    .DWELL (2)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .UP     (up),
    .DOWN   (down),
    .MODE   (mode),
    .SPEED  (speed),
    .STEP   (step),
    .AUTO   (auto_out),
    .PAUSED (paused)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; equals the expected prescaler value.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // STEP is high when the low (4-speed) bits of the count are all ones.
  function automatic logic exp_step(input int c, input logic [1:0] s, input logic p);
    logic [3:0] m;
    logic [3:0] c4;
    m  = 4'hF >> s;
    c4 = c[3:0];
    return ((c4 & m) == m) && !p;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic u, input logic d, input logic m);
    up = u; down = d; mode = m;
    next_cycle();
    up = 1'b0; down = 1'b0; mode = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      chk({tag, " step"}, step, (k == 15));
    end
  endtask

  task automatic wait_step(input string tag);
    int n;
    n = 0;
    while (step !== 1'b1 && n < 64) begin
      next_cycle();
      n++;
    end
    chk({tag, " step seen"}, step, 1);
  endtask

  function automatic vec_t mk(input logic u, input logic d, input logic m,
                              input logic [1:0] s, input logic a, input logic p);
    vec_t v;
    v.up = u; v.down = d; v.mode = m;
    v.speed = s; v.exp_auto = a; v.paused = p;
    return v;
  endfunction

  vec_t vecs[13];
  int   lv[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lv = '{0, 1, 2, 3, 2, 1, 0};
    vecs[0]  = mk(1, 0, 0, 2'd1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 2'd1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 2'd2, 0, 0);
    vecs[3]  = mk(1, 0, 0, 2'd3, 0, 0);
    vecs[4]  = mk(0, 0, 0, 2'd3, 0, 0);
    vecs[5]  = mk(0, 0, 0, 2'd3, 0, 0);
`ifdef BLINK_SPEED_SAT_EN
    vecs[6]  = mk(1, 0, 0, 2'd3, 0, 0);
    vecs[7]  = mk(0, 1, 0, 2'd2, 0, 0);
    vecs[8]  = mk(0, 1, 0, 2'd1, 0, 0);
    vecs[9]  = mk(0, 1, 0, 2'd0, 0, 0);
    vecs[10] = mk(0, 1, 0, 2'd0, 0, 0);
`else
    vecs[6]  = mk(1, 0, 0, 2'd0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 2'd3, 0, 0);
    vecs[8]  = mk(0, 1, 0, 2'd2, 0, 0);
    vecs[9]  = mk(0, 1, 0, 2'd1, 0, 0);
    vecs[10] = mk(0, 1, 0, 2'd0, 0, 0);
`endif
    vecs[11] = mk(1, 1, 0, 2'd0, 0, 0);
    vecs[12] = mk(1, 0, 1, 2'd0, 1, 0);

    // Reset state before any clock edge
    #1;
    chk("reset speed",  speed,    0);
    chk("reset auto",   auto_out, 0);
    chk("reset paused", paused,   0);
    chk("reset step",   step,     0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle at speed 0: first STEP at count 15
    idle_check("idle");

    // Manual-mode table
    for (int i = 0; i < 13; i++) begin
      pulse(vecs[i].up, vecs[i].down, vecs[i].mode);
      chk($sformatf("vec%0d speed", i),  speed,    vecs[i].speed);
      chk($sformatf("vec%0d auto", i),   auto_out, vecs[i].exp_auto);
      chk($sformatf("vec%0d paused", i), paused,   vecs[i].paused);
      chk($sformatf("vec%0d step", i),   step,
          exp_step(cyc, vecs[i].speed, vecs[i].paused));
    end

    // Auto sweep 0,1,2,3,2,1,0 with two STEPs per level
    for (int idx = 0; idx < 7; idx++) begin
      for (int p = 0; p < 2; p++) begin
        wait_step("sweep");
        chk($sformatf("sweep lvl%0d pulse%0d speed", idx, p), speed, lv[idx]);
        next_cycle();
        if (idx == 1 && p == 0) begin
          pulse(1, 0, 0);
          chk("auto single up speed", speed, 1);
          chk("auto single up auto", auto_out, 1);
        end
      end
    end

    // Ramp on up to speed 2, take one STEP there, then pause
    wait_step("ramp1a");
    chk("ramp speed 1a", speed, 1);
    next_cycle();
    wait_step("ramp1b");
    chk("ramp speed 1b", speed, 1);
    next_cycle();
    wait_step("ramp2");
    chk("ramp speed 2", speed, 2);
    next_cycle();
    pulse(1, 1, 0);
    chk("pause paused", paused,   1);
    chk("pause auto",   auto_out, 1);
    chk("pause speed",  speed,    2);
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      chk("pause hold step",   step,   0);
      chk("pause hold speed",  speed,  2);
      chk("pause hold paused", paused, 1);
    end

    // Resume: one more STEP at 2 (dwell kept), then up to 3 (dir kept)
    pulse(1, 1, 0);
    chk("resume paused", paused,   0);
    chk("resume auto",   auto_out, 1);
    wait_step("resume2");
    chk("resume dwell speed", speed, 2);
    next_cycle();
    wait_step("resume3");
    chk("resume dir speed", speed, 3);

    // Asynchronous reset away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async rst speed",  speed,    0);
    chk("async rst auto",   auto_out, 0);
    chk("async rst step",   step,     0);
    chk("async rst paused", paused,   0);
    @(negedge clk);
    rst = 1'b0;
    idle_check("post-reset");

    // MODE from PAUSE returns to MANUAL with speed kept
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    chk("pm speed 2", speed, 2);
    pulse(0, 0, 1);
    chk("pm auto", auto_out, 1);
    pulse(1, 1, 0);
    chk("pm paused", paused, 1);
    chk("pm paused speed", speed, 2);
    pulse(0, 0, 1);
    chk("pm manual auto",   auto_out, 0);
    chk("pm manual paused", paused,   0);
    chk("pm manual speed",  speed,    2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
